// File: rtl/sig_test_sequencer.sv
// -----------------------------------------------------------------------------
// sig_test_sequencer
// On-chip self-test controller for the microprocessor core. Runs a two-pass
// signature test: each pass pulses the core reset, counts a stimulus value onto
// the core i_pins and folds the scrambled core observables into a 16-bit
// rotate/add signature. Pass A uses SEED_A, pass B uses SEED_B; both results
// are latched and reported.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous active-low reset
//   start      in   1  one-cycle request, only honoured in IDLE
//   obs        in   8  pre-XOR-reduced core observables
//   dut_reset  out  1  active-high reset to the microprocessor
//   stimulus   out  8  counter driven onto the core i_pins
//   sig_a      out 16  latched pass-A signature
//   sig_b      out 16  latched pass-B signature
//   busy       out  1  high while a test is in progress
//   done       out  1  one-cycle pulse when both signatures are valid
//   pass       out  1  signature comparison result
//
// Optional feature macro: SIG_COMPARE_EN
//   defined   : EXP_A / EXP_B parameters, pass <= (sig_a==EXP_A)&&(sig_b==EXP_B)
//               when DONE is entered; holds until the next start or reset.
//   undefined : no compare logic, pass tied to 0.
// -----------------------------------------------------------------------------
module sig_test_sequencer #(
    parameter logic [7:0]  SEED_A     = 8'hAA,
    parameter logic [7:0]  SEED_B     = 8'hFF,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned RUN_LEN    = 255
`ifdef SIG_COMPARE_EN
    ,
    parameter logic [15:0] EXP_A      = 16'h0000,
    parameter logic [15:0] EXP_B      = 16'h0000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  obs,
    output logic        dut_reset,
    output logic [7:0]  stimulus,
    output logic [15:0] sig_a,
    output logic [15:0] sig_b,
    output logic        busy,
    output logic        done,
    output logic        pass
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_RUN   = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic       PASS_A   = 1'b0;
    localparam logic       PASS_B   = 1'b1;
    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [7:0] RUN_LAST = 8'(RUN_LEN);

    // One signature update: 8-bit add of the scrambled observable into the
    // low byte, then rotate the whole word left by one bit.
    function automatic logic [15:0] sig_step(input logic [15:0] acc, input logic [7:0] scr);
        logic [7:0] add;
        add = acc[7:0] + scr;
        return {acc[14:8], add, acc[15]};
    endfunction

    state_t      r_state,     w_state_nxt;
    logic        r_dut_reset, w_dut_reset_nxt;
    logic [7:0]  r_stim,      w_stim_nxt;
    logic [15:0] r_acc,       w_acc_nxt;
    logic [15:0] r_sig_a,     w_sig_a_nxt;
    logic [15:0] r_sig_b,     w_sig_b_nxt;
    logic        r_busy,      w_busy_nxt;
    logic        r_done,      w_done_nxt;
    logic        r_pass_sel,  w_pass_sel_nxt;
    logic [3:0]  r_cnt,       w_cnt_nxt;

    logic [7:0]  w_scr;
    assign w_scr = (r_pass_sel == PASS_B) ? (SEED_B ^ obs) : (SEED_A ^ obs);

`ifdef SIG_COMPARE_EN
    logic r_pass, w_pass_nxt;
    logic w_cmp;
    // r_acc holds the final pass-B signature in the LATCH cycle.
    assign w_cmp = (r_sig_a == EXP_A) && (r_acc == EXP_B);
    assign pass  = r_pass;
`else
    assign pass  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-register values for every sequencer register.
    always_comb begin
        w_state_nxt     = r_state;
        w_dut_reset_nxt = r_dut_reset;
        w_stim_nxt      = r_stim;
        w_acc_nxt       = r_acc;
        w_sig_a_nxt     = r_sig_a;
        w_sig_b_nxt     = r_sig_b;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_sel_nxt  = r_pass_sel;
        w_cnt_nxt       = r_cnt;
`ifdef SIG_COMPARE_EN
        w_pass_nxt      = r_pass;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_RST;
                    w_dut_reset_nxt = 1'b1;
                    w_stim_nxt      = 8'd0;
                    w_acc_nxt       = 16'd0;
                    w_busy_nxt      = 1'b1;
                    w_pass_sel_nxt  = PASS_A;
                    w_cnt_nxt       = 4'd0;
`ifdef SIG_COMPARE_EN
                    w_pass_nxt      = 1'b0;
`endif
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_RST: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt     = ST_RUN;
                    w_dut_reset_nxt = 1'b0;
                end else begin
                    w_cnt_nxt       = r_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (r_stim == RUN_LAST) begin
                    w_state_nxt = ST_LATCH;
                    // Pass B's core reset starts in the LATCH cycle, so the
                    // LATCH cycle counts as the first reset cycle of pass B.
                    if (r_pass_sel == PASS_A) begin
                        w_dut_reset_nxt = 1'b1;
                        w_cnt_nxt       = 4'd0;
                    end else begin
                        w_dut_reset_nxt = 1'b0;
                    end
                end else begin
                    w_stim_nxt = r_stim + 8'd1;
                    w_acc_nxt  = sig_step(r_acc, w_scr);
                end
            end
            ST_LATCH: begin
                if (r_pass_sel == PASS_A) begin
                    w_sig_a_nxt    = r_acc;
                    w_pass_sel_nxt = PASS_B;
                    w_stim_nxt     = 8'd0;
                    w_acc_nxt      = 16'd0;
                    if (r_cnt == RST_LAST) begin
                        w_state_nxt     = ST_RUN;
                        w_dut_reset_nxt = 1'b0;
                    end else begin
                        w_state_nxt     = ST_RST;
                        w_cnt_nxt       = r_cnt + 4'd1;
                    end
                end else begin
                    w_sig_b_nxt = r_acc;
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
`ifdef SIG_COMPARE_EN
                    w_pass_nxt  = w_cmp;
`endif
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_dut_reset_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dut_reset <= 1'b0;
            r_stim      <= 8'd0;
            r_acc       <= 16'd0;
            r_sig_a     <= 16'd0;
            r_sig_b     <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_sel  <= PASS_A;
            r_cnt       <= 4'd0;
`ifdef SIG_COMPARE_EN
            r_pass      <= 1'b0;
`endif
        end else begin
            r_dut_reset <= w_dut_reset_nxt;
            r_stim      <= w_stim_nxt;
            r_acc       <= w_acc_nxt;
            r_sig_a     <= w_sig_a_nxt;
            r_sig_b     <= w_sig_b_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass_sel  <= w_pass_sel_nxt;
            r_cnt       <= w_cnt_nxt;
`ifdef SIG_COMPARE_EN
            r_pass      <= w_pass_nxt;
`endif
        end
    end

    assign dut_reset = r_dut_reset;
    assign stimulus  = r_stim;
    assign sig_a     = r_sig_a;
    assign sig_b     = r_sig_b;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sig_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sig_test_sequencer
// Three sequencer instances with different RST_CYCLES / RUN_LEN / seeds share
// one clock, reset, start and obs. A behavioural model derives the expected
// per-cycle outputs from the pass schedule and the expected signatures from a
// recorded history of obs using plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sig_test_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] obs;

    logic [2:0] dr_w, busy_w, done_w, pass_w;
    logic [7:0]  stim_w [3];
    logic [15:0] sa_w   [3];
    logic [15:0] sb_w   [3];

    int vectors     = 0;
    int miscompares = 0;

    localparam int N_CYC = 524;

    int         r_p  [3] = '{4, 2, 3};
    int         l_p  [3] = '{255, 1, 2};
    logic [7:0] sd_a [3] = '{8'hAA, 8'hAA, 8'hAA};
    logic [7:0] sd_b [3] = '{8'hFF, 8'hFF, 8'h00};
`ifdef SIG_COMPARE_EN
    logic [15:0] ex_a [3] = '{16'h0000, 16'h0000, 16'h03FC};
    logic [15:0] ex_b [3] = '{16'h0000, 16'h0000, 16'h0000};
`endif

    logic [7:0]  obs_hist [0:N_CYC+4];
    logic [15:0] prev_a   [3];
    logic [15:0] prev_b   [3];

    always #5 clk = ~clk;

    sig_test_sequencer u_full (
        .clk(clk), .reset(reset), .start(start), .obs(obs),
        .dut_reset(dr_w[0]), .stimulus(stim_w[0]), .sig_a(sa_w[0]), .sig_b(sb_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0])
    );

    sig_test_sequencer #(.RST_CYCLES(2), .RUN_LEN(1)) u_one (
        .clk(clk), .reset(reset), .start(start), .obs(obs),
        .dut_reset(dr_w[1]), .stimulus(stim_w[1]), .sig_a(sa_w[1]), .sig_b(sb_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1])
    );

    sig_test_sequencer #(.RST_CYCLES(3), .RUN_LEN(2), .SEED_B(8'h00)
`ifdef SIG_COMPARE_EN
        , .EXP_A(16'h03FC), .EXP_B(16'h0000)
`endif
    ) u_two (
        .clk(clk), .reset(reset), .start(start), .obs(obs),
        .dut_reset(dr_w[2]), .stimulus(stim_w[2]), .sig_a(sa_w[2]), .sig_b(sb_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Schedule model: pass length P = R + L + 1 cycles; cycle c is the state
    // seen after the c-th clock edge following the start-accepting edge.
    function automatic int exp_stim(input int c, input int r, input int l);
        int p;
        p = r + l + 1;
        if (c < r)                return 0;
        else if (c <= r + l)      return c - r;
        else if (c == p)          return l;
        else if (c < p + r)       return 0;
        else if (c <= p + r + l)  return c - p - r;
        else                      return l;
    endfunction

    function automatic bit exp_dr(input int c, input int r, input int l);
        int p;
        p = r + l + 1;
        return (c < r) || (c >= p && c < p + r);
    endfunction

    // Signature of l updates using the obs values applied before edges
    // first_k .. first_k+l-1: low byte add, then rotate left by one.
    function automatic logic [15:0] model_sig(input int first_k, input int l, input logic [7:0] seed);
        int a, low, scr;
        a = 0;
        for (int i = 0; i < l; i++) begin
            scr = int'(seed ^ obs_hist[first_k + i]);
            low = (a % 256 + scr) % 256;
            a   = ((a % 32768) / 256) * 512 + low * 2 + a / 32768;
        end
        return 16'(a);
    endfunction

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_dut_reset[%0d]", tag, d), 32'(dr_w[d]),   32'h0);
            chk($sformatf("%s_stimulus[%0d]",  tag, d), 32'(stim_w[d]), 32'h0);
            chk($sformatf("%s_sig_a[%0d]",     tag, d), 32'(sa_w[d]),   32'h0);
            chk($sformatf("%s_sig_b[%0d]",     tag, d), 32'(sb_w[d]),   32'h0);
            chk($sformatf("%s_busy[%0d]",      tag, d), 32'(busy_w[d]), 32'h0);
            chk($sformatf("%s_done[%0d]",      tag, d), 32'(done_w[d]), 32'h0);
            chk($sformatf("%s_pass[%0d]",      tag, d), 32'(pass_w[d]), 32'h0);
        end
    endtask

    // One complete test run, entered and left on a negative edge.
    task automatic do_run(input bit rnd, input bit poke, input string name);
        int e_busy [3];
        int e_done [3];
        int e_dr   [3];
        int e_stim [3];
        int e_hold [3];
        int p, c;
        logic [15:0] ea, eb;
        logic        ep;
        for (int d = 0; d < 3; d++) begin
            e_busy[d] = 0; e_done[d] = 0; e_dr[d] = 0; e_stim[d] = 0; e_hold[d] = 0;
        end
        start = 1'b1;
        obs   = 8'h00;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= N_CYC; k++) begin
            c = k - 1;
            for (int d = 0; d < 3; d++) begin
                p = r_p[d] + l_p[d] + 1;
                if (busy_w[d] !== 1'(c <= 2 * p))                 e_busy[d]++;
                if (done_w[d] !== 1'(c == 2 * p + 1))             e_done[d]++;
                if (dr_w[d]   !== 1'(exp_dr(c, r_p[d], l_p[d])))  e_dr[d]++;
                if (stim_w[d] !== 8'(exp_stim(c, r_p[d], l_p[d]))) e_stim[d]++;
                if (c == 0 && (sa_w[d] !== prev_a[d] || sb_w[d] !== prev_b[d])) e_hold[d]++;
            end
            obs         = rnd ? 8'($urandom) : 8'h00;
            obs_hist[k] = obs;
            start       = (poke && k == 5);
            @(negedge clk);
        end
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            p  = r_p[d] + l_p[d] + 1;
            ea = model_sig(r_p[d] + 1, l_p[d], sd_a[d]);
            eb = model_sig(p + r_p[d] + 1, l_p[d], sd_b[d]);
`ifdef SIG_COMPARE_EN
            ep = (ea == ex_a[d]) && (eb == ex_b[d]);
`else
            ep = 1'b0;
`endif
            chk($sformatf("%s_busy_errs[%0d]", name, d), 32'(e_busy[d]), 32'd0);
            chk($sformatf("%s_done_errs[%0d]", name, d), 32'(e_done[d]), 32'd0);
            chk($sformatf("%s_dutrst_errs[%0d]", name, d), 32'(e_dr[d]), 32'd0);
            chk($sformatf("%s_stim_errs[%0d]", name, d), 32'(e_stim[d]), 32'd0);
            chk($sformatf("%s_sig_hold_errs[%0d]", name, d), 32'(e_hold[d]), 32'd0);
            chk($sformatf("%s_sig_a[%0d]", name, d), 32'(sa_w[d]), 32'(ea));
            chk($sformatf("%s_sig_b[%0d]", name, d), 32'(sb_w[d]), 32'(eb));
            chk($sformatf("%s_pass[%0d]", name, d), 32'(pass_w[d]), 32'(ep));
            prev_a[d] = ea;
            prev_b[d] = eb;
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        obs   = 8'h00;
        for (int d = 0; d < 3; d++) begin
            prev_a[d] = 16'h0000;
            prev_b[d] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // Directed run with obs=0 and a start pulse while busy.
        do_run(1'b0, 1'b1, "zero");
        chk("zero_one_sig_a",  32'(sa_w[1]),   32'h0154);
        chk("zero_two_sig_a",  32'(sa_w[2]),   32'h03FC);
        chk("zero_two_sig_b",  32'(sb_w[2]),   32'h0000);
        chk("zero_full_stim",  32'(stim_w[0]), 32'hFF);

        // Randomised observables.
        do_run(1'b1, 1'b0, "rnd1");
        do_run(1'b1, 1'b1, "rnd2");

        // Reset asserted in the middle of RUN.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy_before_reset", 32'(busy_w[0]), 32'h1);
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("start_in_reset_busy", 32'(busy_w[0]), 32'h0);
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
